// File: rtl/fetch_queue_stage.sv
// fetch_queue_stage: fetch PC owner with a DEPTH-entry prefetch queue.
// Ports: CLK/RST (async active-high), imem_req/imem_addr/ihit/instr to
// instruction memory, stall/pc_control/nxt_pc from the pipeline,
// out_valid/out_instr/out_pc/out_npc/out_pred/count describe the head.
// Optional macro FETCH_PREDICT_EN: static backward-taken beq/bne prediction.
module fetch_queue_stage #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic                         CLK,
    input  logic                         RST,
    output logic                         imem_req,
    output logic [31:0]                  imem_addr,
    input  logic                         ihit,
    input  logic [31:0]                  instr,
    input  logic                         stall,
    input  logic                         pc_control,
    input  logic [31:0]                  nxt_pc,
    output logic                         out_valid,
    output logic [31:0]                  out_instr,
    output logic [31:0]                  out_pc,
    output logic [31:0]                  out_npc,
    output logic                         out_pred,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [31:0]   r_pc;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [31:0]   r_q_pc    [DEPTH];
    logic [31:0]   r_q_instr [DEPTH];

    logic          w_push;
    logic          w_pop;
    logic          w_pred;
    logic [31:0]   w_npc;

    assign imem_req  = !pc_control && (r_count != CW'(DEPTH));
    assign imem_addr = r_pc;
    assign count     = r_count;
    assign out_valid = (r_count != '0);

    assign w_push = imem_req && ihit;
    // A redirect suppresses the pop as well as the push.
    assign w_pop  = out_valid && !stall && !pc_control;

`ifdef FETCH_PREDICT_EN
    logic          r_q_pred  [DEPTH];
    logic          w_is_br;
    logic [31:0]   w_off;

    // Backward beq/bne: negative immediate means predicted taken.
    assign w_is_br = (instr[31:26] == 6'b000100 ||
                      instr[31:26] == 6'b000101) && instr[15];
    assign w_off   = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign w_pred  = w_is_br;
    assign w_npc   = r_pc + 32'd4 + (w_is_br ? w_off : 32'd0);

    always_ff @(posedge CLK) begin
        if (w_push)
            r_q_pred[r_tail] <= w_pred;
    end

    assign out_pred = out_valid ? r_q_pred[r_head] : 1'b0;
`else
    assign w_pred   = 1'b0;
    assign w_npc    = r_pc + 32'd4;
    assign out_pred = w_pred;
`endif

    // Payload storage needs no reset; out_* are gated by out_valid.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_q_pc[r_tail]    <= r_pc;
            r_q_instr[r_tail] <= instr;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pc    <= PC_RESET;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (pc_control) begin
            r_pc    <= nxt_pc;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_pc   <= w_npc;
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop)
                r_head <= r_head + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    assign out_instr = out_valid ? r_q_instr[r_head] : 32'd0;
    assign out_pc    = out_valid ? r_q_pc[r_head] : 32'd0;
    assign out_npc   = out_valid ? r_q_pc[r_head] + 32'd4 : 32'd0;

endmodule

// File: tb/tb_fetch_queue_stage.sv
// tb_fetch_queue_stage: directed stimulus, queue-based reference model
// compared on every falling edge, plus literal spot checks.
module tb_fetch_queue_stage;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] PC_RESET = 32'h0000_0000;
    localparam int          CW       = $clog2(DEPTH+1);

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          imem_req;
    logic [31:0]   imem_addr;
    logic          ihit = 1'b0;
    logic [31:0]   instr;
    logic          stall = 1'b0;
    logic          pc_control = 1'b0;
    logic [31:0]   nxt_pc = 32'd0;
    logic          out_valid;
    logic [31:0]   out_instr;
    logic [31:0]   out_pc;
    logic [31:0]   out_npc;
    logic          out_pred;
    logic [CW-1:0] count;

    logic          auto_i = 1'b1;
    logic [31:0]   instr_d = 32'd0;

    int checks = 0;
    int errors = 0;

    assign instr = auto_i ? (32'hA000_0000 | imem_addr) : instr_d;

    always #5 CLK = ~CLK;

    fetch_queue_stage #(.DEPTH(DEPTH), .PC_RESET(PC_RESET)) dut (
        .CLK(CLK), .RST(RST),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .ihit(ihit), .instr(instr),
        .stall(stall), .pc_control(pc_control), .nxt_pc(nxt_pc),
        .out_valid(out_valid), .out_instr(out_instr),
        .out_pc(out_pc), .out_npc(out_npc),
        .out_pred(out_pred), .count(count)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain FIFO of fetched entries plus the fetch PC.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        pred;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mpc;

    function automatic logic m_pred(input logic [31:0] i);
`ifdef FETCH_PREDICT_EN
        return (i[31:26] == 6'd4 || i[31:26] == 6'd5) && i[15];
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            mq.delete();
            mpc = PC_RESET;
        end else if (pc_control) begin
            mq.delete();
            mpc = nxt_pc;
        end else begin
            bit do_push;
            bit do_pop;
            ent_t e;
            do_push = (mq.size() < DEPTH) && ihit;
            do_pop  = (mq.size() > 0) && !stall;
            if (do_pop)
                void'(mq.pop_front());
            if (do_push) begin
                e.pc   = mpc;
                e.ins  = instr;
                e.pred = m_pred(instr);
                mq.push_back(e);
                if (e.pred)
                    mpc = mpc + 32'd4 + {{14{instr[15]}}, instr[15:0], 2'b00};
                else
                    mpc = mpc + 32'd4;
            end
        end
    end

    always @(negedge CLK) begin
        bit v;
        v = mq.size() > 0;
        chk("imem_req", {31'd0, imem_req},
            {31'd0, !pc_control && (mq.size() < DEPTH)});
        chk("imem_addr", imem_addr, mpc);
        chk("count", 32'(count), 32'(mq.size()));
        chk("out_valid", {31'd0, out_valid}, {31'd0, v});
        chk("out_instr", out_instr, v ? mq[0].ins : 32'd0);
        chk("out_pc", out_pc, v ? mq[0].pc : 32'd0);
        chk("out_npc", out_npc, v ? mq[0].pc + 32'd4 : 32'd0);
        chk("out_pred", {31'd0, out_pred}, {31'd0, v ? mq[0].pred : 1'b0});
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd1);
        chk("rst_cnt", 32'(count), 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        RST  = 1'b0;
        ihit = 1'b1;
        chk("t1_addr0", imem_addr, 32'h0);
        tick();
        chk("t1_addr1", imem_addr, 32'h4);
        chk("t1_outpc", out_pc, 32'h0);
        chk("t1_cnt1", 32'(count), 32'd1);
        tick();
        chk("t1_addr2", imem_addr, 32'h8);
        chk("t1_cnt2", 32'(count), 32'd1);
        chk("t1_outpc2", out_pc, 32'h4);

        // Fill under stall from a redirect to 0.
        pc_control = 1'b1;
        nxt_pc     = 32'h0;
        tick();
        pc_control = 1'b0;
        stall      = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            tick();
            chk("fill_cnt", 32'(count), 32'(i));
        end
        chk("full_req", {31'd0, imem_req}, 32'd0);
        chk("full_addr", imem_addr, 32'h10);
        tick();
        chk("full_hold", imem_addr, 32'h10);
        stall = 1'b0;
        tick();
        stall = 1'b1;
        chk("pop1_cnt", 32'(count), 32'd3);
        chk("pop1_req", {31'd0, imem_req}, 32'd1);
        tick();
        chk("refill_cnt", 32'(count), 32'd4);
        chk("refill_addr", imem_addr, 32'h14);

        // Down to 3 entries, then redirect with a colliding ihit.
        ihit  = 1'b0;
        stall = 1'b0;
        tick();
        stall = 1'b1;
        chk("three_cnt", 32'(count), 32'd3);
        ihit       = 1'b1;
        pc_control = 1'b1;
        nxt_pc     = 32'h400;
        tick();
        pc_control = 1'b0;
        chk("rd_cnt", 32'(count), 32'd0);
        chk("rd_valid", {31'd0, out_valid}, 32'd0);
        chk("rd_addr", imem_addr, 32'h400);
        tick();
        chk("rd_cnt1", 32'(count), 32'd1);
        chk("rd_outpc", out_pc, 32'h400);

        // Steady state at two entries: push and pop every cycle.
        tick();
        stall = 1'b0;
        chk("ss_cnt0", 32'(count), 32'd2);
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("ss_cnt", 32'(count), 32'd2);
            chk("ss_outpc", out_pc, 32'h400 + 32'(4 * i));
        end

        // Backward bne at 0x20.
        pc_control = 1'b1;
        nxt_pc     = 32'h20;
        tick();
        pc_control = 1'b0;
        auto_i     = 1'b0;
        instr_d    = 32'h1400_FFFC;
        tick();
        ihit   = 1'b0;
        auto_i = 1'b1;
        chk("br_outpc", out_pc, 32'h20);
`ifdef FETCH_PREDICT_EN
        chk("br_addr", imem_addr, 32'h14);
        chk("br_pred", {31'd0, out_pred}, 32'd1);
`else
        chk("br_addr", imem_addr, 32'h24);
        chk("br_pred", {31'd0, out_pred}, 32'd0);
`endif

        // 32-bit wrap of the fetch PC.
        pc_control = 1'b1;
        nxt_pc     = 32'hFFFF_FFFC;
        tick();
        pc_control = 1'b0;
        ihit       = 1'b1;
        tick();
        ihit = 1'b0;
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_pc", out_pc, 32'hFFFF_FFFC);
        chk("wrap_npc", out_npc, 32'h0);

        // Fill, then asynchronous reset in mid-cycle.
        stall = 1'b1;
        ihit  = 1'b1;
        repeat (DEPTH + 1) tick();
        chk("pre_rst_cnt", 32'(count), 32'(DEPTH));
        @(posedge CLK);
        #3;
        RST = 1'b1;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_cnt", 32'(count), 32'd0);
        chk("arst_addr", imem_addr, PC_RESET);
        tick();
        RST = 1'b0;
        tick();
        chk("post_rst_cnt", 32'(count), 32'd1);
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
